// File: rtl/dmem_ctrl_pkg.sv
// Shared types and constants for the data-memory access controller.
package dmem_ctrl_pkg;

  localparam int unsigned NPORT = 2;

  localparam logic SZ_BYTE = 1'b0;
  localparam logic SZ_HALF = 1'b1;

  localparam logic PORT_MEM = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StAcc0,
    StAcc1,
    StFin
  } state_e;

  // Halfword loads take the second (high) byte straight from memory; sign only applies to bytes.
  function automatic logic [15:0] extend_load(input logic       half,
                                              input logic       sgn,
                                              input logic [7:0] rdata,
                                              input logic [7:0] lo);
    if (half) begin
      return {rdata, lo};
    end
    if (sgn) begin
      return {{8{rdata[7]}}, rdata};
    end
    return {8'h00, rdata};
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Request/response and byte-memory bus of the data-memory access controller.
interface dmem_access_ctrl_if #(
  parameter int unsigned ADDR_W = 16
);
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [1:0]          req_we;
  logic [1:0]          req_size;
  logic [1:0]          req_signed;
  logic [2*ADDR_W-1:0] req_addr;
  logic [31:0]         req_wdata;
  logic [1:0]          rsp_valid;
  logic [15:0]         rsp_rdata;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_we;
  logic                mem_re;
  logic [7:0]          mem_wdata;
  logic [7:0]          mem_rdata;
  logic                busy;

  // Requesters and the memory sit on the master side.
  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, mem_addr, mem_we, mem_re, mem_wdata, busy
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, mem_addr, mem_we, mem_re, mem_wdata, busy
  );
endinterface

// File: rtl/dmem_arb.sv
// Two-port request arbiter. Fixed priority (port 0 first) by default;
// define DMEM_ARB_RR_EN for round-robin with the last winner demoted.
module dmem_arb
  import dmem_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NPORT-1:0] i_req_valid,
  input  logic             i_enable,
  output logic [NPORT-1:0] o_grant
);

`ifdef DMEM_ARB_RR_EN
  logic r_ptr;  // port that currently has highest priority

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= PORT_MEM;
    end else if (|o_grant) begin
      r_ptr <= o_grant[PORT_MEM] ? PORT_DBG : PORT_MEM;
    end
  end

  always_comb begin
    o_grant = '0;
    if (i_enable) begin
      if (r_ptr == PORT_MEM) begin
        if (i_req_valid[PORT_MEM])      o_grant[PORT_MEM] = 1'b1;
        else if (i_req_valid[PORT_DBG]) o_grant[PORT_DBG] = 1'b1;
      end else begin
        if (i_req_valid[PORT_DBG])      o_grant[PORT_DBG] = 1'b1;
        else if (i_req_valid[PORT_MEM]) o_grant[PORT_MEM] = 1'b1;
      end
    end
  end
`else
  logic w_unused_clk_rst;
  assign w_unused_clk_rst = clk ^ rst_n;

  always_comb begin
    o_grant = '0;
    if (i_enable) begin
      if (i_req_valid[PORT_MEM])      o_grant[PORT_MEM] = 1'b1;
      else if (i_req_valid[PORT_DBG]) o_grant[PORT_DBG] = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/dmem_access_ctrl.sv
// Sequences byte/halfword requests from two ports onto a byte-wide data memory.
// Arbitration mode is selected in dmem_arb by DMEM_ARB_RR_EN.
module dmem_access_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input logic               clk,
  input logic               rst_n,
  dmem_access_ctrl_if.slave io_bus
);

  logic [NPORT-1:0]  w_grant;
  logic              w_enable;
  logic              w_hs;
  logic              w_hs_id;
  state_e            r_state;
  state_e            w_state_next;

  logic              r_we;
  logic              r_size;
  logic              r_signed;
  logic              r_id;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_wdata;
  logic [7:0]        r_lo;

  assign w_enable = (r_state == StIdle) || (r_state == StFin);

  dmem_arb u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req_valid (io_bus.req_valid),
    .i_enable    (w_enable),
    .o_grant     (w_grant)
  );

  assign io_bus.req_ready = w_grant;
  assign w_hs             = |w_grant;
  assign w_hs_id          = w_grant[PORT_DBG];
  assign io_bus.busy      = (r_state != StIdle);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_hs) w_state_next = StAcc0;
      StAcc0:  w_state_next = (r_size == SZ_HALF) ? StAcc1 : StFin;
      StAcc1:  w_state_next = StFin;
      StFin:   w_state_next = w_hs ? StAcc0 : StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Request fields are only sampled on the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we     <= 1'b0;
      r_size   <= SZ_BYTE;
      r_signed <= 1'b0;
      r_id     <= PORT_MEM;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_lo     <= '0;
    end else begin
      if (w_hs) begin
        r_we     <= io_bus.req_we[w_hs_id];
        r_size   <= io_bus.req_size[w_hs_id];
        r_signed <= io_bus.req_signed[w_hs_id];
        r_id     <= w_hs_id;
        r_addr   <= w_hs_id ? io_bus.req_addr[2*ADDR_W-1:ADDR_W] : io_bus.req_addr[ADDR_W-1:0];
        r_wdata  <= w_hs_id ? io_bus.req_wdata[31:16] : io_bus.req_wdata[15:0];
      end
      if ((r_state == StAcc1) && !r_we) begin
        r_lo <= io_bus.mem_rdata;
      end
    end
  end

  always_comb begin
    io_bus.mem_addr  = '0;
    io_bus.mem_we    = 1'b0;
    io_bus.mem_re    = 1'b0;
    io_bus.mem_wdata = '0;
    io_bus.rsp_valid = '0;
    io_bus.rsp_rdata = '0;
    unique case (r_state)
      StAcc0: begin
        io_bus.mem_addr  = r_addr;
        io_bus.mem_we    = r_we;
        io_bus.mem_re    = ~r_we;
        io_bus.mem_wdata = r_we ? r_wdata[7:0] : 8'h00;
      end
      StAcc1: begin
        io_bus.mem_addr  = r_addr + ADDR_W'(1);
        io_bus.mem_we    = r_we;
        io_bus.mem_re    = ~r_we;
        io_bus.mem_wdata = r_we ? r_wdata[15:8] : 8'h00;
      end
      StFin: begin
        io_bus.rsp_valid = (r_id == PORT_DBG) ? 2'b10 : 2'b01;
        io_bus.rsp_rdata = r_we ? 16'h0000
                                : extend_load(r_size == SZ_HALF, r_signed, io_bus.mem_rdata, r_lo);
      end
      default: ;
    endcase
  end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequences and arbitrates all accesses to the byte-wide data memory.
- Two requesters share the memory: port 0 is the pipeline MEM stage, port 1 is the loader/debug port.
- Each request is a byte or halfword load/store. The block splits it into one or two byte accesses (little-endian, addr then addr+1), assembles and extends load data, and returns a one-cycle response.
- The pipeline stalls on req_ready low.

Parameters:
- ADDR_W, 16, byte-address width. Address arithmetic wraps modulo 2^ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  2  per-port request valid; bit i = port i.
- req_ready  out  2  per-port accept; at most one bit high.
- req_we  in  2  per-port: 1 = store, 0 = load.
- req_size  in  2  per-port: 0 = byte, 1 = halfword.
- req_signed  in  2  per-port: sign-extend byte loads; ignored for halfword.
- req_addr  in  2*ADDR_W  per-port address; port i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  32  per-port store data; port i at [i*16 +: 16].
- rsp_valid  out  2  one-hot completion pulse to the owning port; also the store ack.
- rsp_rdata  out  16  load data, valid only with rsp_valid; 0 for stores.
- mem_addr  out  ADDR_W  byte address to memory.
- mem_we  out  1  byte write strobe.
- mem_re  out  1  byte read strobe.
- mem_wdata  out  8  write byte.
- mem_rdata  in  8  read byte, valid the cycle after mem_re.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, round-robin pointer=port 0.
  - req_ready, rsp_valid, rsp_rdata, mem_* and busy all 0.
  - Captured request registers cleared.
- FSM states: IDLE, ACC0, ACC1, FIN.
- Accept:
  - req_ready is driven only in IDLE or FIN, and only to the arbitration winner among the valid ports.
  - Handshake = req_valid[i] & req_ready[i].
  - On handshake, latch we, size, signed, addr, wdata and port id, then go to ACC0.
- ACC0:
  - mem_addr=addr.
  - Store: mem_we=1, mem_wdata=wdata[7:0]. Load: mem_re=1.
  - Next state: ACC1 if size=1, else FIN.
- ACC1:
  - mem_addr=addr+1 (0xFFFF wraps to 0x0000).
  - Store: mem_we=1, mem_wdata=wdata[15:8]. Load: mem_re=1.
  - Load: capture mem_rdata as the low byte at the end of the cycle.
  - Next state: FIN.
- FIN:
  - rsp_valid[id]=1 for exactly this cycle.
  - rsp_rdata is combinational in FIN:
    - halfword load = {mem_rdata, low}
    - byte unsigned = {8'h00, mem_rdata}
    - byte signed = {{8{mem_rdata[7]}}, mem_rdata}
    - store = 16'h0000
  - Next state: ACC0 if a new handshake occurs this cycle (back-to-back), else IDLE.
- Latency, counted from the handshake cycle c0 to rsp_valid:
  - byte access: c2
  - halfword access: c3
  - Peak throughput: one byte access per 2 cycles, one halfword per 3 cycles.
- Arbitration (default): fixed priority, port 0 beats port 1. A losing port keeps req_valid high and waits.
- Request signals are sampled only at handshake. Changes while not ready are ignored.
- mem_we and mem_re are never high together, and are 0 in IDLE and FIN.
- Reset mid-operation:
  - Aborts immediately; no rsp is issued.
  - A halfword store interrupted after ACC0 leaves byte 0 written. This is accepted behaviour.
- Misaligned halfword (odd addr) is legal and needs no extra cycles.

Optional Feature:
- Macro: DMEM_ARB_RR_EN.
  - Defined: round-robin arbitration. After a grant, the granted port becomes lowest priority for the next arbitration; the pointer resets to port 0.
  - Undefined: fixed priority, port 0 highest. The pointer register is not instantiated.

Decomposition:
- Package dmem_ctrl_pkg holds:
  - state enum (IDLE, ACC0, ACC1, FIN)
  - size codes SZ_BYTE=0, SZ_HALF=1
  - port indices PORT_MEM=0, PORT_DBG=1
  - NPORT=2
- Sub-module dmem_arb:
  - Inputs: req_valid, enable (IDLE|FIN), clk/rst_n for the RR pointer.
  - Output: one-hot grant.
  - Contains the DMEM_ARB_RR_EN logic.

Test Plan:
- Preload mem[1]=8'h01, mem[2]=8'h02. Port 0 halfword unsigned load at addr 1 -> rsp_valid[0] at c3, rsp_rdata=16'h0201.
- mem[5]=8'h80. Port 0 byte signed load at 5 -> 16'hFF80 at c2. Same with req_signed=0 -> 16'h0080.
- Port 1 halfword store 16'hBEEF at 16'h0010 -> mem[0x10]=8'hEF, mem[0x11]=8'hBE; rsp_valid[1] at c3 with rsp_rdata=0.
- Both ports valid every cycle:
  - fixed mode: port 0 is always granted and port 1 starves.
  - DMEM_ARB_RR_EN: grants alternate 0,1,0,1, with back-to-back accepts in FIN.
- Halfword load at 16'hFFFF -> second access at 16'h0000; rsp_rdata={mem[0],mem[FFFF]}.
- Assert rst_n=0 during ACC1 of a halfword store of 16'h1234 at addr 8 -> mem[8]=8'h34, mem[9] unchanged, no rsp_valid, outputs 0, state IDLE.
